// File: rtl/bus_sample_fifo.sv
// bus_sample_fifo: single-clock valid/ready FIFO that buffers bus samples for a downstream
// consumer. The head entry is held in a dedicated output register, so out_data is registered
// and reads 0 out of reset.
// Optional build macro: BUS_SAMPLE_FIFO_PARITY_EN adds a stored even-parity bit per entry and a
// sticky par_err output.
module bus_sample_fifo #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
`ifdef BUS_SAMPLE_FIFO_PARITY_EN
    output logic             par_err,
`endif
    output logic [CW-1:0]    count
);

    localparam int unsigned PW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        StEmpty  = 2'd0,
        StActive = 2'd1,
        StFull   = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q, rd_ptr_inc;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push, pop;
    logic             head_from_in;

    assign in_ready   = (state_q != StFull);
    assign out_valid  = (state_q != StEmpty);
    assign out_data   = out_data_q;
    assign count      = count_q;

    assign push       = in_valid & in_ready;
    assign pop        = out_valid & out_ready;
    assign rd_ptr_inc = rd_ptr_q + PW'(1);

    // The new head bypasses memory when it is the entry being written this very cycle.
    assign head_from_in = push && (wr_ptr_q == rd_ptr_inc);

    // Next occupancy, next state and next head-of-queue register value.
    always_comb begin
        count_d    = count_q + CW'(push) - CW'(pop);
        state_d    = state_q;
        out_data_d = out_data_q;
        unique case (state_q)
            StEmpty:  if (push) state_d = StActive;
            StActive: begin
                if (count_d == '0) begin
                    state_d = StEmpty;
                end else if (count_d == CW'(DEPTH)) begin
                    state_d = StFull;
                end
            end
            StFull:   if (pop) state_d = StActive;
            default:  state_d = StEmpty;
        endcase
        if (pop && (count_d != '0)) begin
            out_data_d = head_from_in ? in_data : mem_q[rd_ptr_inc];
        end else if (push && (state_q == StEmpty)) begin
            out_data_d = in_data;
        end
    end

    // Control state, pointers and the registered head entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StEmpty;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            out_data_q <= out_data_d;
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_inc;
        end
    end

    // Sample storage; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_data;
    end

`ifdef BUS_SAMPLE_FIFO_PARITY_EN
    logic [DEPTH-1:0] par_q;
    logic             out_par_q, out_par_d;
    logic             par_err_q;

    assign par_err = par_err_q;

    // Parity of the head entry follows the same selection as its data.
    always_comb begin
        out_par_d = out_par_q;
        if (pop && (count_d != '0)) begin
            out_par_d = head_from_in ? ^in_data : par_q[rd_ptr_inc];
        end else if (push && (state_q == StEmpty)) begin
            out_par_d = ^in_data;
        end
    end

    // Stored parity bit per entry, written alongside the data.
    always_ff @(posedge clk) begin
        if (push) par_q[wr_ptr_q] <= ^in_data;
    end

    // Head parity register and sticky error flag, checked as each entry pops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_par_q <= 1'b0;
            par_err_q <= 1'b0;
        end else begin
            out_par_q <= out_par_d;
            if (pop && (out_par_q != ^out_data_q)) par_err_q <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_bus_sample_fifo.sv
// Directed bench for bus_sample_fifo: reset, fill, drain, streaming, full boundary, async
// reset and, in the parity build, a corrupted parity bit.
module tb_bus_sample_fifo;

    localparam int unsigned WIDTH = 9;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CW-1:0]    count;
`ifdef BUS_SAMPLE_FIFO_PARITY_EN
    logic             par_err;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bus_sample_fifo #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
`ifdef BUS_SAMPLE_FIFO_PARITY_EN
        .par_err  (par_err),
`endif
        .count    (count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        // Reset held for three cycles.
        repeat (3) tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_count",     32'(count),     32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_out_valid", 32'(out_valid), 32'd0);
        chk("post_rst_count",     32'(count),     32'd0);

        // Fill 001..008 with no consumer.
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = WIDTH'(i);
            chk("fill_in_ready", 32'(in_ready), 32'd1);
            tick();
            chk("fill_count", 32'(count), 32'(i));
        end
        chk("full_in_ready", 32'(in_ready), 32'd0);
        in_data = 9'h1FF;
        tick();
        chk("held_off_count",    32'(count),    32'd8);
        chk("held_off_in_ready", 32'(in_ready), 32'd0);
        chk("full_head",         32'(out_data), 32'h001);

        // Drain in order.
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            chk("drain_valid", 32'(out_valid), 32'd1);
            chk("drain_data",  32'(out_data),  32'(i));
            tick();
        end
        chk("drained_valid", 32'(out_valid), 32'd0);
        chk("drained_count", 32'(count),     32'd0);

        // Streaming: output trails input by one cycle, occupancy stays 1.
        in_valid = 1'b1;
        in_data  = 9'h100;
        tick();
        for (int k = 1; k <= 20; k++) begin
            in_data = WIDTH'(9'h100 + k);
            chk("stream_valid", 32'(out_valid), 32'd1);
            chk("stream_data",  32'(out_data),  32'(9'h100 + k - 1));
            chk("stream_count", 32'(count),     32'd1);
            tick();
        end
        in_valid = 1'b0;
        chk("stream_last", 32'(out_data), 32'h114);
        tick();
        chk("stream_end_count", 32'(count), 32'd0);
        out_ready = 1'b0;

        // Full boundary: simultaneous offer and pop while full.
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = WIDTH'(9'h010 + i);
            tick();
        end
        chk("fb_count_full", 32'(count), 32'd8);
        in_data   = 9'h055;
        out_ready = 1'b1;
        chk("fb_in_ready_full", 32'(in_ready), 32'd0);
        tick();
        chk("fb_count_after_pop", 32'(count),     32'd7);
        chk("fb_in_ready_active", 32'(in_ready),  32'd1);
        chk("fb_out_valid",       32'(out_valid), 32'd1);
        chk("fb_head",            32'(out_data),  32'h012);
        out_ready = 1'b0;
        tick();
        chk("fb_count_refill", 32'(count),    32'd8);
        chk("fb_in_ready_off", 32'(in_ready), 32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 2; i <= 8; i++) begin
            chk("fb_drain", 32'(out_data), 32'(9'h010 + i));
            tick();
        end
        chk("fb_drain_last", 32'(out_data), 32'h055);
        tick();
        chk("fb_empty", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        // Async reset with five entries buffered.
        for (int i = 1; i <= 5; i++) begin
            in_valid = 1'b1;
            in_data  = WIDTH'(9'h020 + i);
            tick();
        end
        in_valid = 1'b0;
        chk("ar_count_before", 32'(count), 32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_count",     32'(count),     32'd0);
        chk("ar_out_valid", 32'(out_valid), 32'd0);
        chk("ar_in_ready",  32'(in_ready),  32'd1);
        chk("ar_out_data",  32'(out_data),  32'd0);
        #1;
        rst_n    = 1'b1;
        in_valid = 1'b1;
        in_data  = 9'h0AA;
        tick();
        in_valid = 1'b0;
        chk("ar_push_valid", 32'(out_valid), 32'd1);
        chk("ar_push_data",  32'(out_data),  32'h0AA);
        chk("ar_push_count", 32'(count),     32'd1);
        out_ready = 1'b1;
        tick();
        chk("ar_pop_count", 32'(count), 32'd0);
        out_ready = 1'b0;

`ifdef BUS_SAMPLE_FIFO_PARITY_EN
        // Corrupt the stored parity of the second entry; error appears after it pops.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("par_rst", 32'(par_err), 32'd0);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = WIDTH'(3 + 2 * i);
            tick();
        end
        in_valid = 1'b0;
        force dut.par_q[1] = 1'b1;
        out_ready = 1'b1;
        tick();
        chk("par_clean_pop", 32'(par_err), 32'd0);
        tick();
        chk("par_err_set", 32'(par_err), 32'd1);
        release dut.par_q[1];
        tick();
        chk("par_err_sticky", 32'(par_err), 32'd1);
        out_ready = 1'b0;
        tick();
        chk("par_err_hold", 32'(par_err), 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
